// File: rtl/dmem_io.sv
// Word-addressed data RAM plus a memory-mapped I/O page: debounced switches,
// sticky write-1-to-clear change flags, and a read/write LED register.
module dmem_io #(
    parameter int DEPTH    = 64,
    parameter int NUM_SW   = 2,
    parameter int NUM_LED  = 8,
    parameter int DEBOUNCE = 4,
    parameter int IO_BASE  = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [31:0]        a,
    input  logic [31:0]        wd,
    output logic [31:0]        rd,
    input  logic [NUM_SW-1:0]  sw,
    output logic [NUM_LED-1:0] led,
    output logic               irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [31:0] RAM_LIMIT      = 32'(4 * DEPTH);
    localparam logic [31:0] SW_STATE_ADDR  = 32'(IO_BASE);
    localparam logic [31:0] SW_EVENT_ADDR  = 32'(IO_BASE + 4);
    localparam logic [31:0] LED_ADDR       = 32'(IO_BASE + 8);
    localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE - 1);

    logic [31:0] mem [DEPTH];

    logic [31:0] a_word;
    logic        ram_sel;
    logic        state_sel;
    logic        event_sel;
    logic        led_sel;
    logic        unused_a;

    logic [NUM_SW-1:0]          s1_q, s1_d;
    logic [NUM_SW-1:0]          s2_q, s2_d;
    logic [NUM_SW-1:0]          stable_q, stable_d;
    logic [NUM_SW-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [NUM_SW-1:0]          evt_q, evt_d;
    logic [NUM_SW-1:0]          evt_set;
    logic [NUM_SW-1:0]          evt_clr;
    logic [NUM_LED-1:0]         led_q, led_d;

    assign a_word    = {a[31:2], 2'b00};
    assign unused_a  = ^a[1:0];
    assign ram_sel   = (a_word < RAM_LIMIT);
    assign state_sel = (a_word == SW_STATE_ADDR);
    assign event_sel = (a_word == SW_EVENT_ADDR);
    assign led_sel   = (a_word == LED_ADDR);

    // RAM is deliberately left without reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we && ram_sel) begin
            mem[a[AW+1:2]] <= wd;
        end
    end

    always_comb begin
        s1_d     = sw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        evt_set  = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
                evt_set[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        evt_clr = (we && event_sel) ? wd[NUM_SW-1:0] : '0;
        // A new set is ORed in after the clear so it wins a same-cycle race.
        evt_d   = (evt_q & ~evt_clr) | evt_set;
        led_d   = (we && led_sel) ? wd[NUM_LED-1:0] : led_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            evt_q    <= '0;
            led_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            evt_q    <= evt_d;
            led_q    <= led_d;
        end
    end

    always_comb begin
        rd = '0;
        if (ram_sel) begin
            rd = mem[a[AW+1:2]];
        end else if (state_sel) begin
            rd[NUM_SW-1:0] = stable_q;
        end else if (event_sel) begin
            rd[NUM_SW-1:0] = evt_q;
        end else if (led_sel) begin
            rd[NUM_LED-1:0] = led_q;
        end
    end

    assign led = led_q;
    assign irq = |evt_q;

endmodule

// File: doc/dmem_io.md
# dmem_io

Parametrised data memory with a memory-mapped I/O window for the single-cycle processor's data port. Word-addressed RAM with synchronous write and combinational read, plus an I/O page above it: debounced switch inputs, sticky per-switch change flags with write-1-to-clear, and a read/write LED register. Sits between the datapath's ALU result, write-data and read-data buses and the board switches and LEDs.

## Interface
- DEPTH, 64: RAM depth in 32-bit words; power of two, ≥2.
- NUM_SW, 2: switch input count, 1..32.
- NUM_LED, 8: LED output count, 1..32.
- DEBOUNCE, 4: consecutive cycles a synchronised switch must differ from its debounced value before the debounced value updates; ≥1.
- IO_BASE, 256: byte address of the I/O page; multiple of 16, ≥ 4*DEPTH.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write enable for the current access.
- a  in  32  byte address; a[1:0] ignored.
- wd  in  32  write data.
- rd  out  32  read data, combinational from a.
- sw  in  NUM_SW  raw asynchronous switch inputs.
- led  out  NUM_LED  LED register.
- irq  out  1  OR of all sticky change flags.

## Operation
- Address map (word-aligned):
  - 0 .. 4*DEPTH-4: RAM word a[log2(DEPTH)+1:2].
  - IO_BASE+0, SW_STATE: read returns debounced switch vector, zero-extended. Writes ignored.
  - IO_BASE+4, SW_EVENT: read returns sticky change flags, zero-extended. A write clears each flag whose wd bit is 1 (write-1-to-clear). Reads do not clear.
  - IO_BASE+8, LED: read returns led, zero-extended. A write loads wd[NUM_LED-1:0].
  - Any other address: read returns 0; write has no effect.
- RAM: written on the clock edge when we is high and the address is in range. Not reset; contents are undefined until written.
- Switch path, per bit: 2-flop synchroniser (s1, s2), then debouncer with debounced value `stable` and counter `cnt`, sized ceil(log2(DEBOUNCE+1)) bits.
  - At each edge, if s2 equals stable, cnt is cleared to 0.
  - If s2 differs from stable and cnt == DEBOUNCE-1: stable takes s2, cnt is cleared to 0, and that bit's event flag is set.
  - If s2 differs from stable otherwise: cnt increments.
  - A glitch shorter than DEBOUNCE synchronised cycles never changes stable.
- Event flags: if a set and a W1C clear of the same bit occur in the same cycle, the set wins. Clearing a bit has no effect on other bits.
- irq = |event flags, combinational from the flag registers.

## Timing
- Reset (asynchronous, immediate): s1, s2, stable, cnt, event flags and led all go to 0. rd follows the map from these values. irq = 0.
- Read latency 0: rd is valid in the same cycle as a.
- A write becomes visible in the cycle after the edge. A same-cycle read of the written address returns the old value.
- Switch latency: for a raw sw change settling before edge 1, s2 changes at edge 2, and stable plus the event flag update at edge 2+DEBOUNCE. With the default DEBOUNCE=4 this is edge 6. irq rises in the same cycle.
- Reset asserted mid-debounce discards the partial count. After release, switches held at 1 re-qualify and set their event flags after 2+DEBOUNCE edges.
- An access in the 4*DEPTH .. IO_BASE-4 gap, or above IO_BASE+8, never aliases RAM.

## Test plan
- Reset, then read IO_BASE, IO_BASE+4 and IO_BASE+8 -> all reads 0; led=0; irq=0.
- Write 0xDEADBEEF to address 0x10, reading 0x10 in the same cycle -> rd shows the old value. Next cycle rd=0xDEADBEEF. A write to 4*DEPTH followed by reads of 0 and 4*DEPTH -> address 0 unchanged, 4*DEPTH reads 0.
- With DEBOUNCE=4, raise sw[0] before edge 1 -> SW_STATE=0 through edge 5; SW_STATE=1, SW_EVENT=1 and irq=1 after edge 6.
- Pulse sw[1] high for 3 cycles -> SW_STATE and SW_EVENT stay 0.
- With SW_EVENT=0b11, write 0b01 to IO_BASE+4 -> SW_EVENT=0b10 and irq=1. Write 0b10 in the same cycle that sw[1] re-qualifies -> bit 1 remains 1.
- Write 0xA5 to IO_BASE+8 -> led=0xA5 and reading IO_BASE+8 returns 0x000000A5. Assert reset asynchronously between edges -> led=0 and irq=0 immediately, without waiting for an edge.
